dm_arbiter: RTL
===============

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, 32, data width of both requesters and the memory port.
REQ-003 Parameter MAX_BURST, 4, maximum consecutive grants to one requester while the other is requesting (range 1..15).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req0, req1  input  1 each  access request from requester 0 (CPU) and requester 1 (DMA/debug).
REQ-007 we0, we1  input  1 each  1 = write, 0 = read; qualified by reqN.
REQ-008 addr0, addr1  input  ADDR_W each  byte address; qualified by reqN.
REQ-009 writedata0, writedata1  input  DATA_W each  write data; qualified by reqN and weN.
REQ-010 gnt0, gnt1  output  1 each  access accepted this cycle.
REQ-011 rvalid0, rvalid1  output  1 each  read data valid for that requester this cycle.
REQ-012 readdata0, readdata1  output  DATA_W each  read data, meaningful only when rvalidN = 1.
REQ-013 addr, writedata, we  output  ADDR_W/DATA_W/1  to DM_synch.
REQ-014 readdata  input  DATA_W  from DM_synch; valid one cycle after the address is presented.

Function
REQ-015 Handshake: requester holds reqN, weN, addrN, writedataN stable until a cycle with gntN = 1; the transfer occurs in that cycle; the requester may deassert or issue a new request next cycle.
REQ-016 gnt0 and gnt1 are combinational from the current req inputs and registered state; never both 1.
REQ-017 No request -> gnt0 = gnt1 = 0, we = 0, addr and writedata hold their last driven values.
REQ-018 Granted cycle: addr, writedata, we are driven combinationally from the granted requester; we = weN of the granted requester.
REQ-019 Read latency: a read granted in cycle t gives rvalidN = 1 in cycle t+1, with readdataN = readdata; rvalidN = 0 in all other cycles.
REQ-020 Writes produce no rvalid; a write granted in cycle t is visible to a read granted in cycle t+1 or later.
REQ-021 Back-to-back grants are allowed every cycle; no bubble between a read and the next access.
REQ-022 Single requester active -> it is granted every cycle (burst limit not applied).
REQ-023 Both requesting -> winner chosen per REQ-030/031.
REQ-024 Burst counter (4 bits) counts consecutive grants to the same requester; reset to 1 on a grant switch; on reaching MAX_BURST with the other requester active, the next grant goes to the other requester.
REQ-025 readdata0/readdata1 are combinational copies of readdata, gated to 0 when the matching rvalid is 0.

Reset
REQ-026 While rst = 1 at a rising edge: gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, we = 0, burst counter = 0, last-grant register = requester 1 (so requester 0 wins the first tie).
REQ-027 During rst, gnt outputs are forced 0 regardless of req inputs; a read granted the cycle before reset asserts returns no rvalid.
REQ-028 addr and writedata reset to 0.

Configuration
REQ-029 Macro DM_ARB_RR_EN selects the tie-break policy.
REQ-030 Defined: round-robin -- on a tie the requester not granted most recently wins, subject to REQ-024.
REQ-031 Undefined: fixed priority -- requester 0 always wins ties, requester 1 granted only when req0 = 0 or requester 0 has hit MAX_BURST consecutive grants.

Structure
REQ-032 Shared package dm_pkg holds ADDR_W/DATA_W defaults, the requester-index type (REQ0/REQ1) and the MAX_BURST default.
REQ-033 The tie-break logic goes in a sub-module dm_arb_pick (inputs: req0, req1, last grant, burst count; output: granted index); dm_arbiter holds all registers and the muxes.
REQ-034 DM_synch is instantiated by the parent, not inside dm_arbiter.

Verification
REQ-035 Bench pairs dm_arbiter with DM_synch, memory preloaded with word 2 at address 8.
REQ-036 req0 read addr 8 alone -> gnt0 same cycle; rvalid0 = 1, readdata0 = 2 next cycle; rvalid1 = 0.
REQ-037 req1 write 42 to addr 8 (cycle t), req0 read addr 8 (cycle t+1) -> readdata0 = 42 at t+2.
REQ-038 req0 and req1 both reading continuously, DM_ARB_RR_EN defined -> grants alternate 0,1,0,1; each rvalid follows its own grant by one cycle.
REQ-039 Same stimulus, macro undefined, MAX_BURST = 4 -> grant pattern 0,0,0,0,1,0,0,0,0,1.
REQ-040 Read granted in cycle t, rst = 1 at the edge ending cycle t -> rvalid0 = 0 in cycle t+1; after rst drops with both requesting, the first grant goes to requester 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, burst limit,
// requester index type and the burst-counter increment helper.
package dm_pkg;

    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_t;

    // Saturating increment so a lone requester never wraps the count back to 0
    function automatic logic [3:0] burst_inc(input logic [3:0] cnt);
        burst_inc = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Tie-break for the two-requester data-memory arbiter.
// Build option: define DM_ARB_RR_EN for round-robin ties, otherwise requester 0 has priority.
module dm_arb_pick
    import dm_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic       req0,
    input  logic       req1,
    input  req_idx_t   last_gnt,
    input  logic [3:0] burst_cnt,
    output req_idx_t   pick
);

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    logic     limit_hit_s;
    req_idx_t other_s;
    req_idx_t pref_s;
    req_idx_t tie_s;

    // On a tie, a requester that has used up its burst must hand over
    always_comb begin
        limit_hit_s = (burst_cnt >= MAX_B);
        other_s     = (last_gnt == REQ0) ? REQ1 : REQ0;
`ifdef DM_ARB_RR_EN
        pref_s      = other_s;
`else
        pref_s      = REQ0;
`endif
        tie_s       = limit_hit_s ? other_s : pref_s;
    end

    // Single requester always wins; nobody requesting leaves a don't-care REQ0
    always_comb begin
        if (req0 && req1) begin
            pick = tie_s;
        end else if (req1) begin
            pick = REQ1;
        end else begin
            pick = REQ0;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the synchronous data memory (DM_synch lives in the parent).
// Tie policy selected by DM_ARB_RR_EN (round-robin) or fixed priority when undefined.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] writedata0,
    input  logic [DATA_W-1:0] writedata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] readdata0,
    output logic [DATA_W-1:0] readdata1,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] writedata,
    output logic              we,
    input  logic [DATA_W-1:0] readdata
);

    req_idx_t          last_r;
    logic [3:0]        cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              rvalid0_r;
    logic              rvalid1_r;
    req_idx_t          pick_s;
    logic              gnt_any_s;

    dm_arb_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .req0      (req0),
        .req1      (req1),
        .last_gnt  (last_r),
        .burst_cnt (cnt_r),
        .pick      (pick_s)
    );

    // Grant decode and memory-port mux; idle cycles replay the last address/data
    always_comb begin
        gnt_any_s = !rst && (req0 || req1);
        gnt0      = gnt_any_s && (pick_s == REQ0);
        gnt1      = gnt_any_s && (pick_s == REQ1);
        if (gnt0) begin
            addr      = addr0;
            writedata = writedata0;
            we        = we0;
        end else if (gnt1) begin
            addr      = addr1;
            writedata = writedata1;
            we        = we1;
        end else begin
            addr      = addr_r;
            writedata = wdata_r;
            we        = 1'b0;
        end
    end

    // Read data is only exposed to the requester whose read completed
    always_comb begin
        rvalid0   = rvalid0_r;
        rvalid1   = rvalid1_r;
        readdata0 = rvalid0_r ? readdata : {DATA_W{1'b0}};
        readdata1 = rvalid1_r ? readdata : {DATA_W{1'b0}};
    end

    // Arbitration history, held port values and one-cycle read-valid pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r    <= REQ1;
            cnt_r     <= 4'd0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
        end else begin
            rvalid0_r <= gnt0 && !we0;
            rvalid1_r <= gnt1 && !we1;
            if (gnt_any_s) begin
                last_r  <= pick_s;
                cnt_r   <= (pick_s == last_r) ? burst_inc(cnt_r) : 4'd1;
                addr_r  <= addr;
                wdata_r <= writedata;
            end
        end
    end

endmodule
